// File: rtl/multiplier_control.sv
// Sequencer for the add-shift signed multiplier: clears A/X, then walks WIDTH
// add-or-subtract / shift pairs over the B register and holds Done until Run drops.
module multiplier_control #(
  parameter int WIDTH = 8
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Run,
  input  logic ClearA_LoadB,
  input  logic M,
  output logic Clr_XA,
  output logic Ld_B,
  output logic Ld_A,
  output logic Add,
  output logic Sub,
  output logic Shift_En,
  output logic Busy,
  output logic Done
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CLEAR = 3'd1;
  localparam logic [2:0] ADD   = 3'd2;
  localparam logic [2:0] SHIFT = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (Run) state <= CLEAR;
        end
        CLEAR: begin
          cnt   <= '0;
          state <= ADD;
        end
        ADD: state <= SHIFT;
        SHIFT: begin
          // The counter stops at its last value; DONE is reached instead of wrapping.
          if (cnt == LAST) begin
            state <= DONE;
          end else begin
            cnt   <= cnt + 1'b1;
            state <= ADD;
          end
        end
        DONE: if (!Run) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    Clr_XA   = 1'b0;
    Ld_B     = 1'b0;
    Ld_A     = 1'b0;
    Add      = 1'b0;
    Sub      = 1'b0;
    Shift_En = 1'b0;
    Busy     = 1'b0;
    Done     = 1'b0;
    case (state)
      IDLE: begin
        Ld_B   = ClearA_LoadB;
        Clr_XA = ClearA_LoadB;
      end
      CLEAR: begin
        Clr_XA = 1'b1;
        Busy   = 1'b1;
      end
      ADD: begin
        Busy = 1'b1;
        // The final multiplier bit carries negative weight in two's complement.
        if (M) begin
          Ld_A = 1'b1;
          Add  = (cnt != LAST);
          Sub  = (cnt == LAST);
        end
      end
      SHIFT: begin
        Busy     = 1'b1;
        Shift_En = 1'b1;
      end
      DONE: Done = 1'b1;
      default: ;
    endcase
  end

endmodule
